// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants and helpers for the multiplier-sharing arbiter.
// Widths and default latency match the external pipelined multiplier.
package mult_share_arbiter_pkg;

  localparam int MULT_W     = 64;
  localparam int MULT_LAT   = 2;
  localparam int MULT_N_REQ = 4;
  localparam int ID_W       = $clog2(MULT_N_REQ);

  // Number of set bits; used to count several response handshakes landing in one cycle.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side bus of the multiplier-sharing arbiter, one lane per requester.
// Handshake: a transfer happens on a posedge where valid and ready of the same lane are both high.
// req_* moves operands into the arbiter; rsp_* moves products out; a raised valid holds its data stable.
interface mult_share_arbiter_if #(
  parameter int N_REQ = mult_share_arbiter_pkg::MULT_N_REQ,
  parameter int W     = mult_share_arbiter_pkg::MULT_W
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*W-1:0]     req_a;
  logic [N_REQ*W-1:0]     req_b;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [N_REQ*2*W-1:0]   rsp_result;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );

endinterface

// File: rtl/mult_rr_arbiter.sv
// Round-robin grant over N_REQ eligible lanes.
// The pointer names the highest-priority lane and moves past the winner on every issue.
module mult_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] elig,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             issue
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    issue    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!issue && elig[idx]) begin
        issue      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (issue) begin
      ptr_q <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external pipelined W x W multiplier between N_REQ requesters.
// A tag pipeline parallel to the multiplier routes each product back to its owner's result slot.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ   = MULT_N_REQ,
  parameter int W       = MULT_W,
  parameter int MUL_LAT = MULT_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_arbiter_if.slave  bus,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [2*W-1:0]       mul_result,
  output logic                 busy,
  output logic [31:0]          ops_done
);

  localparam int TAG_ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]     inflight;
  logic [N_REQ-1:0]     rsp_valid_q;
  logic [N_REQ*2*W-1:0] rsp_q;
  logic [N_REQ-1:0]     elig;
  logic [N_REQ-1:0]     grant;
  logic [N_REQ-1:0]     acc;
  logic [N_REQ-1:0]     cap_mask;
  logic [TAG_ID_W-1:0]  gnt_id;
  logic                 issue;

  logic                 tag_vld [MUL_LAT];
  logic [TAG_ID_W-1:0]  tag_id  [MUL_LAT];

  // A lane with an op in flight or an unaccepted result is skipped; reset blocks any grant.
  assign elig = bus.req_valid & ~inflight & ~rsp_valid_q & {N_REQ{~rst}};

  mult_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (TAG_ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .elig     (elig),
    .grant    (grant),
    .grant_id (gnt_id),
    .issue    (issue)
  );

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_q;

  assign mul_a = issue ? bus.req_a[int'(gnt_id)*W +: W] : '0;
  assign mul_b = issue ? bus.req_b[int'(gnt_id)*W +: W] : '0;

  assign acc  = rsp_valid_q & bus.rsp_ready;
  assign busy = (|inflight) | (|rsp_valid_q);

  always_comb begin
    cap_mask = '0;
    if (tag_vld[MUL_LAT-1]) begin
      cap_mask[tag_id[MUL_LAT-1]] = 1'b1;
    end
  end

  // Clearing the tags on reset is what discards products still inside the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_vld[s] <= 1'b0;
        tag_id[s]  <= '0;
      end
      inflight    <= '0;
      rsp_valid_q <= '0;
      rsp_q       <= '0;
      ops_done    <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_id[0]  <= gnt_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
      inflight    <= (inflight | grant) & ~cap_mask;
      rsp_valid_q <= (rsp_valid_q & ~acc) | cap_mask;
      if (tag_vld[MUL_LAT-1]) begin
        rsp_q[int'(tag_id[MUL_LAT-1])*2*W +: 2*W] <= mul_result;
      end
      ops_done <= ops_done + 32'(popcount8(8'(acc)));
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: external multiplier model, per-cycle reference model,
// directed scenarios with hand-computed expectations.
module tb_mult_share_arbiter;
  import mult_share_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int W   = MULT_W;
  localparam int LAT = MULT_LAT;
  localparam int RW  = 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]  mul_a, mul_b;
  logic [RW-1:0] mul_result;
  logic          busy;
  logic [31:0]   ops_done;
  int            cyc = 0;

  mult_share_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  mult_share_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier: LAT-stage pipeline, no reset, no stall.
  logic [RW-1:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    for (int s = 1; s < LAT; s++) mp[s] <= mp[s-1];
  end
  assign mul_result = mp[LAT-1];

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int gnt_ids[$];
  int gnt_cycs[$];
  int last_gnt_cyc [N];
  int ops_req [N];
  int ops_gnt [N];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Each requester is idle, waiting on a countdown, or holding a result.
  bit            m_on = 1'b0;
  int            m_ptr;
  int            m_cnt  [N];
  bit            m_pend [N];
  bit            m_held [N];
  logic [RW-1:0] m_prod [N];
  logic [RW-1:0] m_res  [N];
  logic [31:0]   m_ops;

  function automatic int model_grant();
    int i;
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (bus.req_valid[i] === 1'b1 && !m_pend[i] && !m_held[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g;
    if (rst) begin
      m_on = 1'b1; m_ptr = 0; m_ops = '0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_pend[i] = 0; m_held[i] = 0; m_res[i] = '0; m_prod[i] = '0;
      end
    end else if (m_on) begin
      g = model_grant();
      for (int i = 0; i < N; i++)
        if (m_held[i] && bus.rsp_ready[i] === 1'b1) begin m_held[i] = 0; m_ops++; end
      for (int i = 0; i < N; i++)
        if (m_pend[i]) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin m_pend[i] = 0; m_held[i] = 1; m_res[i] = m_prod[i]; end
        end
      if (g >= 0) begin
        m_pend[g] = 1; m_cnt[g] = LAT;
        m_prod[g] = {{W{1'b0}}, bus.req_a[g*W +: W]} * {{W{1'b0}}, bus.req_b[g*W +: W]};
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    int g;
    logic [N-1:0]   e_rdy, e_rv;
    logic [W-1:0]   e_a, e_b;
    logic [N*RW-1:0] e_res;
    bit e_busy;
    @(negedge clk);
    if (m_on) begin
      g = model_grant();
      e_rdy = '0; e_a = '0; e_b = '0; e_rv = '0; e_busy = 0;
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        e_a = bus.req_a[g*W +: W];
        e_b = bus.req_b[g*W +: W];
      end
      for (int i = 0; i < N; i++) begin
        e_rv[i] = m_held[i];
        e_res[i*RW +: RW] = m_res[i];
        if (m_pend[i] || m_held[i]) e_busy = 1;
      end
      check("cyc_req_ready",  bus.req_ready,  e_rdy);
      check("cyc_mul_a",      mul_a,          e_a);
      check("cyc_mul_b",      mul_b,          e_b);
      check("cyc_rsp_valid",  bus.rsp_valid,  e_rv);
      check("cyc_rsp_result", bus.rsp_result, e_res);
      check("cyc_busy",       busy,           e_busy);
      check("cyc_ops_done",   ops_done,       m_ops);
    end
  end

  // Grant log, observed on the requester side.
  initial forever begin
    @(negedge clk);
    if (m_on)
      for (int i = 0; i < N; i++)
        if (bus.req_ready[i] === 1'b1) begin
          gnt_ids.push_back(i); gnt_cycs.push_back(cyc); last_gnt_cyc[i] = cyc;
        end
  end

  // ---------------- driver ----------------
  // Requester i keeps req_valid up while it has ops that were asked for but not yet granted.
  initial begin
    logic [N-1:0] seen;
    bus.req_valid = '0;
    forever begin
      @(negedge clk);
      seen = bus.req_ready & bus.req_valid;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (seen[i] === 1'b1) ops_gnt[i]++;
        bus.req_valid[i] = (ops_req[i] != ops_gnt[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic set_op(input int i, input int n, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    ops_req[i] += n;
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input int lim, output int t);
    t = -1;
    for (int k = 0; k < lim && t < 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid[i] === 1'b1) t = cyc;
    end
    if (t < 0) check("wait_rsp_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_gnt(input int i, input int prev, input int lim);
    bit ok = 0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk); #1;
      if (last_gnt_cyc[i] != prev) ok = 1;
    end
    if (!ok) check("wait_gnt_timeout", 1'b0, 1'b1);
  endtask

  task automatic accept(input int i);
    step(); bus.rsp_ready[i] = 1'b1;
    step(); bus.rsp_ready[i] = 1'b0;
  endtask

  task automatic check_grants(input string name, input int base);
    int k = 0;
    check({name, "_count"}, gnt_ids.size() - base, exp_q.size());
    while (exp_q.size() > 0) begin
      check(name, gnt_ids[base + k], exp_q.pop_front());
      k++;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t, base, prev, r, n1, n2, hits;
    int rise [N];
    bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
    for (int i = 0; i < N; i++) begin ops_req[i] = 0; ops_gnt[i] = 0; last_gnt_cyc[i] = -1; end

    do_reset();
    @(negedge clk);
    check("rst_req_ready",  bus.req_ready,  4'h0);
    check("rst_rsp_valid",  bus.rsp_valid,  4'h0);
    check("rst_rsp_result", bus.rsp_result, 512'h0);
    check("rst_mul_a",      mul_a,          64'h0);
    check("rst_busy",       busy,           1'b0);
    check("rst_ops_done",   ops_done,       32'd0);

    // Single op, latency 3 from the issue cycle.
    step(); set_op(0, 1, 64'd3, 64'd5);
    wait_rsp(0, 20, t);
    check("t1_latency", t - last_gnt_cyc[0], 3);
    check("t1_result", bus.rsp_result[RW-1:0], 128'd15);
    accept(0);
    @(negedge clk);
    check("t1_ops_done", ops_done, 32'd1);
    check("t1_rsp_clear", bus.rsp_valid[0], 1'b0);

    // Full-width operands.
    step(); set_op(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_rsp(0, 20, t);
    check("t2_result", bus.rsp_result[RW-1:0], 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    accept(0);
    @(negedge clk);
    check("t2_ops_done", ops_done, 32'd2);

    // All four at once from reset.
    do_reset();
    base = gnt_ids.size();
    step();
    for (int i = 0; i < N; i++) begin
      set_op(i, 1, 64'(i + 2), 64'(i + 10));
      rise[i] = -1;
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (bus.rsp_valid[i] === 1'b1 && rise[i] < 0) rise[i] = cyc;
    end
    #1;
    for (int i = 0; i < N; i++) exp_q.push_back(8'(i));
    check_grants("t3_grant", base);
    check("t3_grant_spacing", gnt_cycs[base + 3] - gnt_cycs[base], 3);
    check("t3_first_latency", rise[0] - gnt_cycs[base], 3);
    for (int i = 1; i < N; i++) check("t3_rise_spacing", rise[i] - rise[i-1], 1);
    check("t3_res0", bus.rsp_result[0*RW +: RW], 128'd20);
    check("t3_res1", bus.rsp_result[1*RW +: RW], 128'd33);
    check("t3_res2", bus.rsp_result[2*RW +: RW], 128'd48);
    check("t3_res3", bus.rsp_result[3*RW +: RW], 128'd65);
    step(); bus.rsp_ready = '1;
    step(); bus.rsp_ready = 4'b0100;

    // Backpressure on requester 1 must not block requester 2.
    base = gnt_ids.size();
    step(); set_op(1, 2, 64'd6, 64'd7); set_op(2, 4, 64'd8, 64'd9);
    repeat (22) @(negedge clk);
    #1;
    n1 = 0; n2 = 0;
    for (int k = base; k < gnt_ids.size(); k++) begin
      if (gnt_ids[k] == 1) n1++;
      if (gnt_ids[k] == 2) n2++;
    end
    check("t4_req1_grants", n1, 1);
    check("t4_req2_grants", n2, 4);
    check("t4_req1_held", bus.rsp_result[1*RW +: RW], 128'd42);
    prev = last_gnt_cyc[1];
    step(); bus.rsp_ready[1] = 1'b1; r = cyc;
    wait_gnt(1, prev, 8);
    check("t4_regrant_cycle", last_gnt_cyc[1], r + 1);
    repeat (6) @(negedge clk);
    check("t4_ops_done", ops_done, 32'd10);
    step(); bus.rsp_ready = '0;

    // Reset one cycle after an issue drops the op.
    do_reset();
    prev = last_gnt_cyc[3];
    step(); set_op(3, 1, 64'd7, 64'd9);
    wait_gnt(3, prev, 8);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 4'h0) hits++;
    end
    check("t5_no_rsp", hits, 0);
    check("t5_busy", busy, 1'b0);
    check("t5_ops_done", ops_done, 32'd0);

    // Fairness between two always-requesting lanes.
    do_reset();
    bus.rsp_ready = '1;
    base = gnt_ids.size();
    step(); set_op(0, 4, 64'd11, 64'd12); set_op(2, 4, 64'd13, 64'd14);
    repeat (24) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin exp_q.push_back(8'd0); exp_q.push_back(8'd2); end
    check_grants("t6_grant", base);
    check("t6_ops_done", ops_done, 32'd8);
    check("t6_res2", bus.rsp_result[2*RW +: RW], 128'd182);
    bus.rsp_ready = '0;

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
